l2_mem_responder: RTL and testbench



---
 rtl/l2_mem_if.sv | 28 ++
 rtl/l2_mem_responder.sv | 127 ++++++++++++
 tb/tb_l2_mem_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_mem_if.sv
// L2 <-> main-memory request/response bundle: level requests from L2,
// single-cycle ready pulse and read block back from memory.
interface l2_mem_if #(
  parameter int TNUM = 18,
  parameter int INUM = 8,
  parameter int BW   = 512
);
  logic            read_L2_MEM;
  logic            write_L2_MEM;
  logic [INUM-1:0] index_L2_MEM;
  logic [TNUM-1:0] tag_L2_MEM;
  logic [TNUM-1:0] write_tag_L2_MEM;
  logic [BW-1:0]   write_data_L2_MEM;
  logic            ready_MEM_L2;
  logic [BW-1:0]   read_data_MEM_L2;

  modport master (
    output read_L2_MEM, write_L2_MEM, index_L2_MEM, tag_L2_MEM,
           write_tag_L2_MEM, write_data_L2_MEM,
    input  ready_MEM_L2, read_data_MEM_L2
  );

  modport slave (
    input  read_L2_MEM, write_L2_MEM, index_L2_MEM, tag_L2_MEM,
           write_tag_L2_MEM, write_data_L2_MEM,
    output ready_MEM_L2, read_data_MEM_L2
  );
endinterface

// File: rtl/l2_mem_responder.sv
// Main-memory responder for the L2 memory-side port: reads, write-backs and
// combined write-back-then-fill with programmable latency. Optional feature
// macro MEM_INIT_PATTERN_EN returns a {6'b0,tag,index} pattern for unwritten lines.
module l2_mem_responder #(
  parameter int TNUM       = 18,
  parameter int INUM       = 8,
  parameter int BW         = 512,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 8,
  parameter int WR_LAT     = 8
) (
  input  logic    clk,
  input  logic    nrst,
  l2_mem_if.slave bus
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                state;
  logic [7:0]            cnt;
  logic                  ready;
  logic [BW-1:0]         rdata;
  logic                  combo_q;
  logic [INUM-1:0]       idx_q;
  logic [TNUM-1:0]       tag_q;
  logic [TNUM-1:0]       wtag_q;
  logic [BW-1:0]         wdata_q;

  logic [BW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_line;
  logic [DEPTH_LOG2-1:0] rd_line;
  logic                  mem_we;
  logic [BW-1:0]         rd_block;

`ifdef MEM_INIT_PATTERN_EN
  logic [DEPTH-1:0]      valid;
  logic [31:0]           pat_word;
`endif

  // Storage line is the low address bits; higher tag bits alias silently.
  always_comb begin
    wr_line = DEPTH_LOG2'({wtag_q, idx_q});
    rd_line = DEPTH_LOG2'({tag_q, idx_q});
    mem_we  = (state == WRITE) && (cnt == 8'd0);
`ifdef MEM_INIT_PATTERN_EN
    pat_word = 32'({tag_q, idx_q});
    rd_block = valid[rd_line] ? mem[rd_line] : {(BW/32){pat_word}};
`else
    rd_block = mem[rd_line];
`endif
  end

  // Storage is never reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (nrst && mem_we) mem[wr_line] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= IDLE;
      cnt     <= '0;
      ready   <= 1'b0;
      rdata   <= '0;
      combo_q <= 1'b0;
      idx_q   <= '0;
      tag_q   <= '0;
      wtag_q  <= '0;
      wdata_q <= '0;
`ifdef MEM_INIT_PATTERN_EN
      valid   <= '0;
`endif
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.read_L2_MEM || bus.write_L2_MEM) begin
            idx_q   <= bus.index_L2_MEM;
            tag_q   <= bus.tag_L2_MEM;
            wtag_q  <= bus.write_tag_L2_MEM;
            wdata_q <= bus.write_data_L2_MEM;
            combo_q <= bus.read_L2_MEM && bus.write_L2_MEM;
            if (bus.write_L2_MEM) begin
              state <= WRITE;
              cnt   <= 8'(WR_LAT - 1);
            end else begin
              state <= READ;
              cnt   <= 8'(RD_LAT - 1);
            end
          end
        end
        WRITE: begin
          if (cnt == 8'd0) begin
`ifdef MEM_INIT_PATTERN_EN
            valid[wr_line] <= 1'b1;
`endif
            if (combo_q) begin
              state <= READ;
              cnt   <= 8'(RD_LAT - 1);
            end else begin
              state <= RESP;
              ready <= 1'b1;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        READ: begin
          if (cnt == 8'd0) begin
            rdata <= rd_block;
            state <= RESP;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_MEM_L2     = ready;
  assign bus.read_data_MEM_L2 = rdata;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Self-checking bench for l2_mem_responder: directed scenarios plus random
// traffic against an associative-array memory model.
module tb_l2_mem_responder;
  localparam int TNUM = 18;
  localparam int INUM = 8;
  localparam int BW   = 512;
  localparam int DL   = 10;
  localparam int RDL  = 8;
  localparam int WRL  = 6;
  localparam int TMO  = 600;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  l2_mem_if #(.TNUM(TNUM), .INUM(INUM), .BW(BW)) bus ();

  l2_mem_responder #(
    .TNUM(TNUM), .INUM(INUM), .BW(BW), .DEPTH_LOG2(DL),
    .RD_LAT(RDL), .WR_LAT(WRL)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] model_mem [int];
  logic [BW-1:0] exp_rdata = '0;

  function automatic int line_of(input logic [TNUM-1:0] t, input logic [INUM-1:0] i);
    return (int'(t) * (1 << INUM) + int'(i)) % (1 << DL);
  endfunction

  function automatic logic [BW-1:0] pattern_of(input logic [TNUM-1:0] t, input logic [INUM-1:0] i);
    logic [31:0] w;
    w = {6'b0, t, i};
    return {(BW/32){w}};
  endfunction

  function automatic bit model_known(input logic [TNUM-1:0] t, input logic [INUM-1:0] i);
`ifdef MEM_INIT_PATTERN_EN
    return 1'b1;
`else
    return model_mem.exists(line_of(t, i));
`endif
  endfunction

  function automatic logic [BW-1:0] model_value(input logic [TNUM-1:0] t, input logic [INUM-1:0] i);
    if (model_mem.exists(line_of(t, i))) return model_mem[line_of(t, i)];
    return pattern_of(t, i);
  endfunction

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int w = 0; w < BW/32; w++) b[w*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic release_req();
    bus.read_L2_MEM  = 1'b0;
    bus.write_L2_MEM = 1'b0;
  endtask

  // Drives one transaction; lat = edges after acceptance until ready seen (-1 on timeout).
  task automatic run_txn(input bit rd, input bit wr, input logic [TNUM-1:0] t,
                         input logic [TNUM-1:0] wt, input logic [INUM-1:0] idx,
                         input logic [BW-1:0] wd, input int drop_after,
                         output int lat, output logic [BW-1:0] data, output bit one_cycle);
    @(negedge clk);
    bus.read_L2_MEM       = rd;
    bus.write_L2_MEM      = wr;
    bus.tag_L2_MEM        = t;
    bus.write_tag_L2_MEM  = wt;
    bus.index_L2_MEM      = idx;
    bus.write_data_L2_MEM = wd;
    @(posedge clk); #1;
    lat = -1;
    data = '0;
    one_cycle = 1'b0;
    for (int n = 1; n <= TMO; n++) begin
      @(posedge clk); #1;
      if (drop_after > 0 && n == drop_after) release_req();
      if (bus.ready_MEM_L2 === 1'b1) begin
        lat = n;
        data = bus.read_data_MEM_L2;
        release_req();
        break;
      end
    end
    release_req();
    if (lat > 0) begin
      @(posedge clk); #1;
      one_cycle = (bus.ready_MEM_L2 === 1'b0);
    end
  endtask

  task automatic test_reset();
    release_req();
    bus.tag_L2_MEM = '0; bus.write_tag_L2_MEM = '0;
    bus.index_L2_MEM = '0; bus.write_data_L2_MEM = '0;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ready_MEM_L2 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.ready_MEM_L2); end
    checks++;
    if (bus.read_data_MEM_L2 !== '0) begin errors++; $display("FAIL reset_data got %h want 0", bus.read_data_MEM_L2); end
    @(negedge clk); nrst = 1'b1;
    exp_rdata = '0;
  endtask

  task automatic test_read_unwritten();
    int lat; logic [BW-1:0] d; bit oc;
    run_txn(1, 0, 18'h00012, '0, 8'h05, '0, -1, lat, d, oc);
    checks++;
    if (lat != RDL) begin errors++; $display("FAIL rd_unwritten_lat got %0d want %0d", lat, RDL); end
    checks++;
    if (!oc) begin errors++; $display("FAIL rd_unwritten_pulse got wide want 1 cycle"); end
`ifdef MEM_INIT_PATTERN_EN
    checks++;
    if (d !== {16{32'h00001205}}) begin errors++; $display("FAIL rd_unwritten_pattern got %h want %h", d, {16{32'h00001205}}); end
`endif
    exp_rdata = d;
  endtask

  task automatic test_write_then_read();
    int lat; logic [BW-1:0] d; bit oc;
    run_txn(0, 1, '0, 18'h00012, 8'h05, {(BW/8){8'hA5}}, -1, lat, d, oc);
    model_mem[line_of(18'h00012, 8'h05)] = {(BW/8){8'hA5}};
    checks++;
    if (lat != WRL) begin errors++; $display("FAIL wr_lat got %0d want %0d", lat, WRL); end
    checks++;
    if (d !== exp_rdata) begin errors++; $display("FAIL wr_data_held got %h want %h", d, exp_rdata); end
    checks++;
    if (!oc) begin errors++; $display("FAIL wr_pulse got wide want 1 cycle"); end
    run_txn(1, 0, 18'h00012, '0, 8'h05, '0, -1, lat, d, oc);
    checks++;
    if (d !== {(BW/8){8'hA5}}) begin errors++; $display("FAIL rd_after_wr got %h want all A5", d); end
    exp_rdata = d;
  endtask

  task automatic test_combined();
    int lat; logic [BW-1:0] d, wd, e; bit oc, known;
    wd = rand_block();
    known = model_known(18'h00004, 8'h10);
    e = model_value(18'h00004, 8'h10);
    run_txn(1, 1, 18'h00004, 18'h00003, 8'h10, wd, -1, lat, d, oc);
    model_mem[line_of(18'h00003, 8'h10)] = wd;
    checks++;
    if (lat != WRL + RDL) begin errors++; $display("FAIL combo_lat got %0d want %0d", lat, WRL + RDL); end
    checks++;
    if (!oc) begin errors++; $display("FAIL combo_single_pulse got wide want 1 cycle"); end
    if (known) begin
      checks++;
      if (d !== e) begin errors++; $display("FAIL combo_data got %h want %h", d, e); end
    end
    run_txn(1, 0, 18'h00003, '0, 8'h10, '0, -1, lat, d, oc);
    checks++;
    if (d !== wd) begin errors++; $display("FAIL combo_written got %h want %h", d, wd); end
    exp_rdata = d;
  endtask

  task automatic test_alias();
    int lat; logic [BW-1:0] d, x1; bit oc;
    x1 = rand_block();
    run_txn(0, 1, '0, 18'h00001, 8'h00, x1, -1, lat, d, oc);
    model_mem[line_of(18'h00001, 8'h00)] = x1;
    run_txn(1, 0, 18'h00005, '0, 8'h00, '0, -1, lat, d, oc);
    checks++;
    if (d !== x1) begin errors++; $display("FAIL alias got %h want %h", d, x1); end
    exp_rdata = d;
  endtask

  task automatic test_reset_mid_write();
    int lat, highs; logic [BW-1:0] d, d0, d1; bit oc;
    d0 = rand_block();
    d1 = ~d0;
    run_txn(0, 1, '0, 18'h00021, 8'h33, d0, -1, lat, d, oc);
    model_mem[line_of(18'h00021, 8'h33)] = d0;
    @(negedge clk);
    bus.write_L2_MEM = 1'b1; bus.write_tag_L2_MEM = 18'h00021;
    bus.index_L2_MEM = 8'h33; bus.write_data_L2_MEM = d1;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b0;
    release_req();
    @(posedge clk); #1;
    checks++;
    if (bus.ready_MEM_L2 !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", bus.ready_MEM_L2); end
    checks++;
    if (bus.read_data_MEM_L2 !== '0) begin errors++; $display("FAIL midrst_data got %h want 0", bus.read_data_MEM_L2); end
    @(negedge clk); nrst = 1'b1;
    exp_rdata = '0;
    highs = 0;
    repeat (WRL + 4) begin
      @(posedge clk); #1;
      if (bus.ready_MEM_L2 === 1'b1) highs++;
    end
    checks++;
    if (highs != 0) begin errors++; $display("FAIL midrst_no_ready got %0d pulses want 0", highs); end
    run_txn(1, 0, 18'h00021, '0, 8'h33, '0, -1, lat, d, oc);
    checks++;
    if (d !== d0) begin errors++; $display("FAIL midrst_not_committed got %h want %h", d, d0); end
    exp_rdata = d;
  endtask

  task automatic test_drop();
    int lat, highs; logic [BW-1:0] d, e; bit oc;
    e = model_value(18'h00012, 8'h05);
    run_txn(1, 0, 18'h00012, '0, 8'h05, '0, 2, lat, d, oc);
    checks++;
    if (lat != RDL) begin errors++; $display("FAIL drop_lat got %0d want %0d", lat, RDL); end
    checks++;
    if (d !== e) begin errors++; $display("FAIL drop_data got %h want %h", d, e); end
    exp_rdata = d;
    highs = 0;
    repeat (RDL + 4) begin
      @(posedge clk); #1;
      if (bus.ready_MEM_L2 === 1'b1) highs++;
    end
    checks++;
    if (highs != 0) begin errors++; $display("FAIL drop_no_second got %0d pulses want 0", highs); end
  endtask

  task automatic test_random();
    int lat, kind, want_lat; logic [BW-1:0] d, wd, e; bit oc, rd, wr, known;
    logic [TNUM-1:0] t, wt; logic [INUM-1:0] idx;
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 2);
      rd = (kind != 1);
      wr = (kind != 0);
      t  = TNUM'($urandom_range(0, 7));
      wt = TNUM'($urandom_range(0, 7));
      idx = INUM'($urandom_range(0, 3));
      wd = rand_block();
      run_txn(rd, wr, t, wt, idx, wd, -1, lat, d, oc);
      if (wr) model_mem[line_of(wt, idx)] = wd;
      known = model_known(t, idx);
      e = rd ? model_value(t, idx) : exp_rdata;
      want_lat = (rd ? RDL : 0) + (wr ? WRL : 0);
      checks++;
      if (lat != want_lat || !oc) begin
        errors++; $display("FAIL rand_timing[%0d] got lat %0d pulse_ok %0b want lat %0d", n, lat, oc, want_lat);
      end
      if (!rd || known) begin
        checks++;
        if (d !== e) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", n, d, e); end
      end
      exp_rdata = d;
    end
  endtask

  initial begin
    test_reset();
    test_read_unwritten();
    test_write_then_read();
    test_combined();
    test_alias();
    test_reset_mid_write();
    test_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
